// File: rtl/mem_req_arbiter_if.sv
// Signal bundle between the two CPU-side requesters, the arbiter and the memory bridge.
// The arbiter uses the slave view; the surrounding pipeline/bridge uses the master view.
interface mem_req_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Fetch/load-store arbiter onto one SRAM-like port: one outstanding transaction,
// data priority with bounded fetch starvation, fetch cancel/discard on flush.
module mem_req_arbiter #(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  mem_req_arbiter_if.slave  arb_if,
  output logic              busy
);

  localparam int unsigned CW = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  state_t        r_state,     w_state_nxt;
  owner_t        r_owner,     w_owner_nxt;
  logic [CW-1:0] r_run_cnt,   w_run_cnt_nxt;
  logic          r_discard,   w_discard_nxt;
  logic          r_bus_req,   w_bus_req_nxt;
  logic          r_bus_wr,    w_bus_wr_nxt;
  logic [1:0]    r_bus_size,  w_bus_size_nxt;
  logic [31:0]   r_bus_addr,  w_bus_addr_nxt;
  logic [3:0]    r_bus_wstrb, w_bus_wstrb_nxt;
  logic [31:0]   r_bus_wdata, w_bus_wdata_nxt;

  logic          w_run_full;
  logic          w_inst_eligible;
  logic          w_grant_data;
  logic          w_grant_inst;

  // A flushed fetch is not eligible, so it cannot force the starvation tie-break.
  assign w_run_full      = (r_run_cnt == CW'(MAX_DATA_RUN));
  assign w_inst_eligible = arb_if.inst_req & ~flush;
  assign w_grant_data    = arb_if.data_req & ~(w_inst_eligible & w_run_full);
  assign w_grant_inst    = w_inst_eligible & ~w_grant_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_INST;
      r_run_cnt   <= '0;
      r_discard   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_size  <= '0;
      r_bus_addr  <= '0;
      r_bus_wstrb <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_run_cnt   <= w_run_cnt_nxt;
      r_discard   <= w_discard_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_wr    <= w_bus_wr_nxt;
      r_bus_size  <= w_bus_size_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_wstrb <= w_bus_wstrb_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_run_cnt_nxt   = r_run_cnt;
    w_discard_nxt   = r_discard;
    w_bus_req_nxt   = r_bus_req;
    w_bus_wr_nxt    = r_bus_wr;
    w_bus_size_nxt  = r_bus_size;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_wstrb_nxt = r_bus_wstrb;
    w_bus_wdata_nxt = r_bus_wdata;

    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_data) begin
          w_state_nxt     = ST_REQ;
          w_owner_nxt     = OWN_DATA;
          w_bus_req_nxt   = 1'b1;
          w_bus_wr_nxt    = arb_if.data_wr;
          w_bus_size_nxt  = arb_if.data_size;
          w_bus_addr_nxt  = arb_if.data_addr;
          w_bus_wstrb_nxt = arb_if.data_wstrb;
          w_bus_wdata_nxt = arb_if.data_wdata;
          if (!arb_if.inst_req)
            w_run_cnt_nxt = '0;
          else if (!w_run_full)
            w_run_cnt_nxt = r_run_cnt + CW'(1);
        end else if (w_grant_inst) begin
          w_state_nxt     = ST_REQ;
          w_owner_nxt     = OWN_INST;
          w_run_cnt_nxt   = '0;
          w_bus_req_nxt   = 1'b1;
          w_bus_wr_nxt    = 1'b0;
          w_bus_size_nxt  = 2'b10;
          w_bus_addr_nxt  = arb_if.inst_addr;
          w_bus_wstrb_nxt = '0;
          w_bus_wdata_nxt = '0;
        end
      end

      ST_REQ: begin
        if (arb_if.bus_addr_ok) begin
          // Accepted downstream; a simultaneous flush can only drop the return.
          w_state_nxt   = ST_WAIT;
          w_bus_req_nxt = 1'b0;
          if (flush && r_owner == OWN_INST)
            w_discard_nxt = 1'b1;
        end else if (flush && r_owner == OWN_INST) begin
          w_state_nxt   = ST_IDLE;
          w_bus_req_nxt = 1'b0;
        end
      end

      ST_WAIT: begin
        if (arb_if.bus_data_ok) begin
          w_state_nxt   = ST_IDLE;
          w_discard_nxt = 1'b0;
        end else if (flush && r_owner == OWN_INST) begin
          w_discard_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_bus_req_nxt = 1'b0;
        w_discard_nxt = 1'b0;
      end
    endcase
  end

  assign arb_if.inst_addr_ok = arb_if.bus_addr_ok & (r_state == ST_REQ) & (r_owner == OWN_INST);
  assign arb_if.data_addr_ok = arb_if.bus_addr_ok & (r_state == ST_REQ) & (r_owner == OWN_DATA);
  assign arb_if.inst_data_ok = arb_if.bus_data_ok & (r_state == ST_WAIT) & (r_owner == OWN_INST)
                               & ~r_discard;
  assign arb_if.data_data_ok = arb_if.bus_data_ok & (r_state == ST_WAIT) & (r_owner == OWN_DATA);
  assign arb_if.inst_rdata   = arb_if.bus_rdata;
  assign arb_if.data_rdata   = arb_if.bus_rdata;

  assign arb_if.bus_req   = r_bus_req;
  assign arb_if.bus_wr    = r_bus_wr;
  assign arb_if.bus_size  = r_bus_size;
  assign arb_if.bus_addr  = r_bus_addr;
  assign arb_if.bus_wstrb = r_bus_wstrb;
  assign arb_if.bus_wdata = r_bus_wdata;

  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter.
module tb_mem_req_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  mem_req_arbiter_if bus_if ();

  mem_req_arbiter #(.MAX_DATA_RUN(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .arb_if (bus_if),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush              = 1'b0;
    bus_if.inst_req    = 1'b0;
    bus_if.inst_addr   = '0;
    bus_if.data_req    = 1'b0;
    bus_if.data_wr     = 1'b0;
    bus_if.data_size   = '0;
    bus_if.data_addr   = '0;
    bus_if.data_wstrb  = '0;
    bus_if.data_wdata  = '0;
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b0;
    bus_if.bus_rdata   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (bus_if.bus_req !== 1'b0) begin bad++; $display("FAIL rst_bus_req got=%b exp=0", bus_if.bus_req); end
    total++; if ({bus_if.bus_wr, bus_if.bus_size, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata} !== 71'd0) begin bad++; $display("FAIL rst_bus_fields got=%h exp=0", {bus_if.bus_wr, bus_if.bus_size, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata}); end
    step();
    step();
    reset = 1'b0;
    bus_if.bus_addr_ok = 1'b1;
    bus_if.bus_data_ok = 1'b1;
    #1;
    total++; if ({bus_if.inst_addr_ok, bus_if.data_addr_ok, bus_if.inst_data_ok, bus_if.data_data_ok} !== 4'b0000) begin bad++; $display("FAIL idle_stray_ok got=%b exp=0000", {bus_if.inst_addr_ok, bus_if.data_addr_ok, bus_if.inst_data_ok, bus_if.data_data_ok}); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_stray_busy got=%b exp=0", busy); end
    clear_inputs();
  endtask

  task automatic test_single_load();
    do_reset();
    bus_if.data_req    = 1'b1;
    bus_if.data_addr   = 32'h0000_1000;
    bus_if.data_size   = 2'b10;
    bus_if.bus_addr_ok = 1'b1;
    #1;
    total++; if (bus_if.bus_req !== 1'b0) begin bad++; $display("FAIL load_req_early got=%b exp=0", bus_if.bus_req); end
    step();
    #1;
    total++; if (bus_if.bus_req !== 1'b1) begin bad++; $display("FAIL load_bus_req got=%b exp=1", bus_if.bus_req); end
    total++; if (bus_if.bus_addr !== 32'h0000_1000) begin bad++; $display("FAIL load_bus_addr got=%h exp=00001000", bus_if.bus_addr); end
    total++; if ({bus_if.data_addr_ok, bus_if.inst_addr_ok} !== 2'b10) begin bad++; $display("FAIL load_addr_ok got=%b exp=10", {bus_if.data_addr_ok, bus_if.inst_addr_ok}); end
    step();
    bus_if.data_req    = 1'b0;
    bus_if.bus_addr_ok = 1'b0;
    #1;
    total++; if ({bus_if.data_addr_ok, bus_if.bus_req, busy, bus_if.data_data_ok} !== 4'b0010) begin bad++; $display("FAIL load_wait got=%b exp=0010", {bus_if.data_addr_ok, bus_if.bus_req, busy, bus_if.data_data_ok}); end
    step();
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata   = 32'hDEAD_BEEF;
    #1;
    total++; if ({bus_if.data_data_ok, bus_if.inst_data_ok} !== 2'b10) begin bad++; $display("FAIL load_data_ok got=%b exp=10", {bus_if.data_data_ok, bus_if.inst_data_ok}); end
    total++; if (bus_if.data_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef", bus_if.data_rdata); end
    step();
    bus_if.bus_data_ok = 1'b0;
    #1;
    total++; if ({busy, bus_if.data_data_ok} !== 2'b00) begin bad++; $display("FAIL load_done got=%b exp=00", {busy, bus_if.data_data_ok}); end
    clear_inputs();
  endtask

  task automatic test_priority();
    bit exp_data [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int n = 0;
    do_reset();
    bus_if.inst_req    = 1'b1;
    bus_if.inst_addr   = 32'hBFC0_0000;
    bus_if.data_req    = 1'b1;
    bus_if.data_wr     = 1'b1;
    bus_if.data_size   = 2'b01;
    bus_if.data_addr   = 32'h0000_8000;
    bus_if.data_wstrb  = 4'hF;
    bus_if.data_wdata  = 32'h5555_AAAA;
    bus_if.bus_addr_ok = 1'b1;
    bus_if.bus_data_ok = 1'b1;
    for (int c = 0; c < 60 && n < 10; c++) begin
      #1;
      if (bus_if.inst_addr_ok || bus_if.data_addr_ok) begin
        total++; if (bus_if.inst_addr_ok && bus_if.data_addr_ok) begin bad++; $display("FAIL prio_both_ok got=11 exp=one-hot"); end
        total++; if (bus_if.data_addr_ok !== exp_data[n]) begin bad++; $display("FAIL prio_order grant=%0d got_data=%b exp_data=%b", n, bus_if.data_addr_ok, exp_data[n]); end
        if (bus_if.inst_addr_ok) begin
          total++; if ({bus_if.bus_wr, bus_if.bus_size, bus_if.bus_wstrb, bus_if.bus_wdata, bus_if.bus_addr} !== {1'b0, 2'b10, 4'h0, 32'h0, 32'hBFC0_0000}) begin bad++; $display("FAIL prio_inst_fields got=%h exp=%h", {bus_if.bus_wr, bus_if.bus_size, bus_if.bus_wstrb, bus_if.bus_wdata, bus_if.bus_addr}, {1'b0, 2'b10, 4'h0, 32'h0, 32'hBFC0_0000}); end
        end
        n++;
      end
      step();
    end
    total++; if (n !== 10) begin bad++; $display("FAIL prio_grant_count got=%0d exp=10", n); end
    clear_inputs();
  endtask

  task automatic test_store_fields();
    do_reset();
    bus_if.data_req   = 1'b1;
    bus_if.data_wr    = 1'b1;
    bus_if.data_size  = 2'b00;
    bus_if.data_addr  = 32'h0000_2004;
    bus_if.data_wstrb = 4'b0100;
    bus_if.data_wdata = 32'h00AB_0000;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({bus_if.bus_req, bus_if.bus_wr, bus_if.bus_size, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata, bus_if.data_addr_ok} !== {1'b1, 1'b1, 2'b00, 32'h0000_2004, 4'b0100, 32'h00AB_0000, 1'b0}) begin bad++; $display("FAIL store_hold cyc=%0d got=%h exp=%h", i, {bus_if.bus_req, bus_if.bus_wr, bus_if.bus_size, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata, bus_if.data_addr_ok}, {1'b1, 1'b1, 2'b00, 32'h0000_2004, 4'b0100, 32'h00AB_0000, 1'b0}); end
      step();
    end
    bus_if.bus_addr_ok = 1'b1;
    #1;
    total++; if ({bus_if.data_addr_ok, bus_if.bus_wstrb, bus_if.bus_wdata} !== {1'b1, 4'b0100, 32'h00AB_0000}) begin bad++; $display("FAIL store_accept got=%h exp=%h", {bus_if.data_addr_ok, bus_if.bus_wstrb, bus_if.bus_wdata}, {1'b1, 4'b0100, 32'h00AB_0000}); end
    step();
    bus_if.data_req    = 1'b0;
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    #1;
    total++; if (bus_if.data_data_ok !== 1'b1) begin bad++; $display("FAIL store_data_ok got=%b exp=1", bus_if.data_data_ok); end
    step();
    bus_if.bus_data_ok = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL store_done_busy got=%b exp=0", busy); end
    clear_inputs();
  endtask

  task automatic test_flush_req();
    do_reset();
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'h0000_3000;
    step();
    flush           = 1'b1;
    bus_if.inst_req = 1'b0;
    #1;
    total++; if ({bus_if.bus_req, bus_if.inst_addr_ok} !== 2'b10) begin bad++; $display("FAIL freq_in_req got=%b exp=10", {bus_if.bus_req, bus_if.inst_addr_ok}); end
    total++; if (bus_if.bus_addr !== 32'h0000_3000) begin bad++; $display("FAIL freq_addr got=%h exp=00003000", bus_if.bus_addr); end
    step();
    flush = 1'b0;
    #1;
    total++; if ({bus_if.bus_req, busy, bus_if.inst_addr_ok} !== 3'b000) begin bad++; $display("FAIL freq_cancel got=%b exp=000", {bus_if.bus_req, busy, bus_if.inst_addr_ok}); end
    // fetch held off while flush is high in IDLE, data still admitted
    bus_if.inst_req    = 1'b1;
    bus_if.inst_addr   = 32'h0000_3004;
    bus_if.bus_addr_ok = 1'b1;
    flush              = 1'b1;
    step();
    #1;
    total++; if ({busy, bus_if.bus_req} !== 2'b00) begin bad++; $display("FAIL fidle_block got=%b exp=00", {busy, bus_if.bus_req}); end
    bus_if.data_req  = 1'b1;
    bus_if.data_addr = 32'h0000_3100;
    step();
    #1;
    total++; if ({bus_if.data_addr_ok, bus_if.inst_addr_ok, bus_if.bus_addr} !== {2'b10, 32'h0000_3100}) begin bad++; $display("FAIL fidle_data got=%h exp=%h", {bus_if.data_addr_ok, bus_if.inst_addr_ok, bus_if.bus_addr}, {2'b10, 32'h0000_3100}); end
    step();
    bus_if.data_req    = 1'b0;
    bus_if.inst_req    = 1'b0;
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    flush              = 1'b0;
    #1;
    total++; if (bus_if.data_data_ok !== 1'b1) begin bad++; $display("FAIL fidle_data_ok got=%b exp=1", bus_if.data_data_ok); end
    step();
    clear_inputs();
  endtask

  task automatic test_flush_wait();
    do_reset();
    bus_if.inst_req    = 1'b1;
    bus_if.inst_addr   = 32'h0000_4000;
    bus_if.bus_addr_ok = 1'b1;
    step();
    #1;
    total++; if (bus_if.inst_addr_ok !== 1'b1) begin bad++; $display("FAIL fwait_addr_ok got=%b exp=1", bus_if.inst_addr_ok); end
    step();
    bus_if.inst_req    = 1'b0;
    bus_if.bus_addr_ok = 1'b0;
    flush              = 1'b1;
    step();
    flush              = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata   = 32'h1111_1111;
    #1;
    total++; if ({bus_if.inst_data_ok, busy} !== 2'b01) begin bad++; $display("FAIL fwait_discard got=%b exp=01", {bus_if.inst_data_ok, busy}); end
    step();
    bus_if.bus_data_ok = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fwait_idle got=%b exp=0", busy); end
    bus_if.inst_req    = 1'b1;
    bus_if.inst_addr   = 32'h0000_4004;
    bus_if.bus_addr_ok = 1'b1;
    step();
    #1;
    total++; if ({bus_if.inst_addr_ok, bus_if.bus_addr} !== {1'b1, 32'h0000_4004}) begin bad++; $display("FAIL fwait_next_addr got=%h exp=%h", {bus_if.inst_addr_ok, bus_if.bus_addr}, {1'b1, 32'h0000_4004}); end
    step();
    bus_if.inst_req    = 1'b0;
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata   = 32'h2222_2222;
    #1;
    total++; if ({bus_if.inst_data_ok, bus_if.inst_rdata} !== {1'b1, 32'h2222_2222}) begin bad++; $display("FAIL fwait_next_data got=%h exp=%h", {bus_if.inst_data_ok, bus_if.inst_rdata}, {1'b1, 32'h2222_2222}); end
    step();
    clear_inputs();
  endtask

  task automatic test_flush_accept();
    do_reset();
    bus_if.inst_req    = 1'b1;
    bus_if.inst_addr   = 32'h0000_5000;
    bus_if.bus_addr_ok = 1'b1;
    step();
    flush = 1'b1;
    #1;
    total++; if (bus_if.inst_addr_ok !== 1'b1) begin bad++; $display("FAIL facc_addr_ok got=%b exp=1", bus_if.inst_addr_ok); end
    step();
    bus_if.inst_req    = 1'b0;
    flush              = 1'b0;
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    #1;
    total++; if (bus_if.inst_data_ok !== 1'b0) begin bad++; $display("FAIL facc_discard got=%b exp=0", bus_if.inst_data_ok); end
    step();
    bus_if.bus_data_ok = 1'b0;
    // flush must not touch a data owner
    bus_if.data_req    = 1'b1;
    bus_if.data_addr   = 32'h0000_6000;
    bus_if.bus_addr_ok = 1'b1;
    step();
    flush = 1'b1;
    #1;
    total++; if (bus_if.data_addr_ok !== 1'b1) begin bad++; $display("FAIL fdata_addr_ok got=%b exp=1", bus_if.data_addr_ok); end
    step();
    bus_if.data_req    = 1'b0;
    bus_if.bus_addr_ok = 1'b0;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fdata_busy got=%b exp=1", busy); end
    step();
    flush              = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    #1;
    total++; if (bus_if.data_data_ok !== 1'b1) begin bad++; $display("FAIL fdata_data_ok got=%b exp=1", bus_if.data_data_ok); end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    bus_if.data_req    = 1'b1;
    bus_if.data_addr   = 32'h0000_1234;
    bus_if.bus_addr_ok = 1'b1;
    step();
    step();
    bus_if.data_req    = 1'b0;
    bus_if.bus_addr_ok = 1'b0;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rwait_pre_busy got=%b exp=1", busy); end
    reset              = 1'b1;
    bus_if.bus_data_ok = 1'b1;
    #1;
    total++; if ({busy, bus_if.bus_req, bus_if.data_data_ok, bus_if.inst_data_ok} !== 4'b0000) begin bad++; $display("FAIL rwait_async got=%b exp=0000", {busy, bus_if.bus_req, bus_if.data_data_ok, bus_if.inst_data_ok}); end
    total++; if (bus_if.bus_addr !== 32'h0) begin bad++; $display("FAIL rwait_addr got=%h exp=00000000", bus_if.bus_addr); end
    step();
    reset = 1'b0;
    #1;
    total++; if ({bus_if.data_data_ok, bus_if.inst_data_ok, busy} !== 3'b000) begin bad++; $display("FAIL rwait_stale got=%b exp=000", {bus_if.data_data_ok, bus_if.inst_data_ok, busy}); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rwait_after got=%b exp=0", busy); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_priority();
    test_store_fields();
    test_flush_req();
    test_flush_wait();
    test_flush_accept();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Two-master arbiter that shares one SRAM-like memory port between the fetch side (instruction requests) and the MEM-stage side (load/store requests). It sits between the CPU pipeline and the memory bridge. It holds one outstanding transaction at a time, gives data requests priority with bounded instruction starvation, and can discard an in-flight fetch on a pipeline flush (exception/ERET).

## Interface
Parameters:
- `MAX_DATA_RUN`, default 4: consecutive data grants allowed while `inst_req` waits; the next tie goes to inst.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: pipeline flush; cancels or discards the current/pending fetch.
- `inst_req` in 1, `inst_addr` in 32: fetch request; held until `inst_addr_ok`.
- `inst_addr_ok` out 1, `inst_data_ok` out 1, `inst_rdata` out 32: fetch accept pulse, return pulse, return data.
- `data_req` in 1, `data_wr` in 1, `data_size` in 2, `data_addr` in 32, `data_wstrb` in 4, `data_wdata` in 32: load/store request; held until `data_addr_ok`.
- `data_addr_ok` out 1, `data_data_ok` out 1, `data_rdata` out 32: load/store accept pulse, return pulse, read data.
- `bus_req` out 1, `bus_wr` out 1, `bus_size` out 2, `bus_addr` out 32, `bus_wstrb` out 4, `bus_wdata` out 32: downstream request, all registered.
- `bus_addr_ok` in 1, `bus_data_ok` in 1, `bus_rdata` in 32: downstream accept, return, data.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: grant a requester and latch its fields into the bus registers; owner := DATA or INST; go to REQ.
  - Grant rule: data wins if `data_req`, unless `inst_req` is also high and `run_cnt == MAX_DATA_RUN`; in that case inst wins.
  - Inst grant drives `bus_wr`=0, `bus_size`=2'b10, `bus_wstrb`=4'b0000, `bus_wdata`=0.
  - In IDLE with `flush`=1, inst is not granted this cycle. Data may still be granted.
- REQ: `bus_req`=1 with the latched fields. On `bus_addr_ok` go to WAIT and pulse the owner's `*_addr_ok` in the same cycle (combinational: `bus_addr_ok & state==REQ & owner`).
  - `flush` in REQ with owner INST and no `bus_addr_ok`: return to IDLE, `bus_req` drops next cycle, no `inst_addr_ok`.
  - `flush` in the same cycle as `bus_addr_ok`: treated as accepted, then discarded as in WAIT.
- WAIT: `bus_req`=0. On `bus_data_ok` go to IDLE.
  - Owner's `*_data_ok` = `bus_data_ok` in WAIT, suppressed if the `discard` flag is set.
  - `*_rdata` = `bus_rdata`, passed through combinationally to both masters.
- `discard` flag: set by `flush` while owner INST is in WAIT, or per the REQ accept case above. Cleared on leaving WAIT.
- Data transactions are never cancelled or discarded; `flush` has no effect on a data owner.
- `run_cnt` (saturating at `MAX_DATA_RUN`):
  - increments on a data grant while `inst_req`=1;
  - clears on any inst grant, or on a data grant with `inst_req`=0.
- `bus_addr_ok`/`bus_data_ok` seen in an unexpected state are ignored.

## Timing
- Reset (async): state IDLE, owner INST, `run_cnt`=0, `discard`=0, `bus_req`=0, all bus fields 0, all `*_ok` outputs 0, `busy`=0.
- A request sampled in IDLE at edge N gives `bus_req`=1 in cycle N+1. Minimum `*_addr_ok` is cycle N+1, when `bus_addr_ok` is already high.
- Minimum turnaround per transaction is 3 cycles (IDLE→REQ→WAIT→IDLE) with a 0-wait bus. The next grant is evaluated in the IDLE cycle after `data_ok`.
- `*_addr_ok` and `*_data_ok` are single-cycle pulses. At most one of inst/data is active per cycle.
- Bus fields stay stable from the cycle `bus_req` rises until `bus_addr_ok`.

## Test plan
- Single load: `data_req`=1, `data_addr`=0x1000, `bus_addr_ok`=1 immediately, `bus_data_ok` 2 cycles later with rdata 0xDEADBEEF → `bus_req` 1 cycle after the request, `data_addr_ok` pulse, `data_data_ok` pulse with `data_rdata`=0xDEADBEEF, then `busy`=0.
- Priority: `inst_req` and `data_req` both held high → data granted first. Inst granted after 4 data grants (`MAX_DATA_RUN`=4), then `run_cnt`=0 and data resumes.
- Store fields: `data_wr`=1, size 2'b00, `data_wstrb`=4'b0100, `data_wdata`=0x00AB0000 → identical values on the bus, held through 3 cycles of `bus_addr_ok`=0.
- Flush in REQ: inst granted, `bus_addr_ok`=0, `flush`=1 → `bus_req` low next cycle, no `inst_addr_ok`, state IDLE.
- Flush in WAIT: fetch accepted, `flush` pulsed, `bus_data_ok`=1 later → `inst_data_ok` stays 0, `busy` drops, next fetch proceeds normally. The same flush during a data transaction → `data_data_ok` still pulses.
- Reset mid-WAIT: assert `reset` asynchronously → all outputs 0 immediately (before the next edge). A stale `bus_data_ok` after reset produces no `*_data_ok`.
